// File: rtl/key_event_fifo.sv
// Keystroke/encoder event FIFO between the scanner and the ARM: edge-detected
// capture, show-ahead registered read port, sticky overflow and interrupt.
module key_event_fifo #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter bit IRQ_PULSE = 1'b0
) (
  input  logic              CLK_LOW,
  input  logic              RST,
  input  logic              KEY_CODE_INT,
  input  logic [7:0]        KEY_CODE_VALUE,
  input  logic              ARM_RD_EN,
  input  logic              ARM_CLR_OVF,
  output logic [7:0]        ARM_RD_DATA,
  output logic              ARM_IRQ,
  output logic [ADDR_W:0]   FIFO_COUNT,
  output logic              FIFO_EMPTY,
  output logic              FIFO_FULL,
  output logic              OVERFLOW
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = (ADDR_W)'(1);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              kint_d;

  logic              push_req;
  logic              pop_ok;
  logic              push_ok;
  logic              drop;
  logic [ADDR_W:0]   count_next;

  // Handshake: there is no back-pressure toward the scanner. A push is offered
  // by a KEY_CODE_INT rising edge and is accepted when the FIFO has room at that
  // edge (a same-cycle pop counts as room); otherwise the code is dropped and
  // OVERFLOW latches. ARM_RD_EN pops the head when non-empty and is a no-op
  // otherwise. Both strobes act on the rising edge where they are seen high.
  always_comb begin
    push_req = KEY_CODE_INT & ~kint_d;
    pop_ok   = ARM_RD_EN & ~FIFO_EMPTY;
    push_ok  = push_req & (~FIFO_FULL | pop_ok);
    drop     = push_req & FIFO_FULL & ~pop_ok;
  end

  always_comb begin
    count_next = FIFO_COUNT;
    case ({push_ok, pop_ok})
      2'b10:   count_next = FIFO_COUNT + CNT_ONE;
      2'b01:   count_next = FIFO_COUNT - CNT_ONE;
      default: count_next = FIFO_COUNT;
    endcase
  end

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge CLK_LOW) begin
    if (push_ok) begin
      mem[wptr] <= KEY_CODE_VALUE;
    end
  end

  always_ff @(posedge CLK_LOW or negedge RST) begin
    if (!RST) begin
      kint_d     <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      FIFO_COUNT <= '0;
      FIFO_EMPTY <= 1'b1;
      FIFO_FULL  <= 1'b0;
    end else begin
      kint_d     <= KEY_CODE_INT;
      if (push_ok) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop_ok) begin
        rptr <= rptr + PTR_ONE;
      end
      FIFO_COUNT <= count_next;
      FIFO_EMPTY <= (count_next == '0);
      FIFO_FULL  <= (count_next == DEPTH_CNT);
    end
  end

  // Read data samples the settled head, so a fresh entry shows one edge later.
  always_ff @(posedge CLK_LOW or negedge RST) begin
    if (!RST) begin
      ARM_RD_DATA <= 8'h00;
    end else if (!FIFO_EMPTY) begin
      ARM_RD_DATA <= mem[rptr];
    end else begin
      ARM_RD_DATA <= 8'h00;
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge CLK_LOW or negedge RST) begin
    if (!RST) begin
      OVERFLOW <= 1'b0;
    end else if (drop) begin
      OVERFLOW <= 1'b1;
    end else if (ARM_CLR_OVF) begin
      OVERFLOW <= 1'b0;
    end
  end

  always_ff @(posedge CLK_LOW or negedge RST) begin
    if (!RST) begin
      ARM_IRQ <= 1'b0;
    end else if (IRQ_PULSE) begin
      ARM_IRQ <= push_ok;
    end else begin
      ARM_IRQ <= (count_next != '0);
    end
  end

endmodule
